// File: rtl/rgb_word_packer_pkg.sv
// Shared video constants and the output-word record used by the RGB word packer.
package video_pkg;

  localparam int BYTE_R          = 0;
  localparam int BYTE_G          = 1;
  localparam int BYTE_B          = 2;
  localparam int PIX_PER_GROUP   = 4;
  localparam int WORDS_PER_GROUP = 3;
  localparam int X_SIZE          = 640;
  localparam int Y_SIZE          = 480;

  localparam logic [3:0] TKEEP_FULL = 4'hF;
  localparam logic [3:0] TKEEP_3B   = 4'h7;

  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } axis_word_t;

  // Lays one pixel out as three consecutive stream bytes, lowest byte first.
  function automatic logic [23:0] pack_pixel(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [23:0] p;
    p = '0;
    p[BYTE_R*8 +: 8] = r;
    p[BYTE_G*8 +: 8] = g;
    p[BYTE_B*8 +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/rgb_word_packer_if.sv
// Pixel input stream and AXI4-Stream word output bundles for the RGB word packer.
interface pix_stream_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       valid;
  logic       sof;
  logic       eol;
  logic       in_stream_ready;

  modport master (output r, g, b, valid, sof, eol, input in_stream_ready);
  modport slave  (input r, g, b, valid, sof, eol, output in_stream_ready);
endinterface

interface axis_word_if;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  modport master (output out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                  out_stream_tuser, out_stream_tvalid, input out_stream_tready);
  modport slave  (input out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                  out_stream_tuser, out_stream_tvalid, output out_stream_tready);
endinterface

// File: rtl/rgb_word_packer_word_fifo.sv
// Small circular FIFO of packed output words; head reads as zero while empty.
module word_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  axis_word_t i_push_word,
  input  logic       i_pop,
  output axis_word_t o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  axis_word_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage needs no reset: the empty gate below hides stale entries.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_word;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/rgb_word_packer.sv
// Packs 24-bit RGB pixels into dense 32-bit AXI4-Stream words, 4 pixels per 3 words.
module rgb_word_packer
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  pix_stream_if.slave  pix,
  axis_word_if.master  axis,
  output logic         align_err
);

  phase_t      r_phase;
  logic [23:0] r_residual;
  logic        r_sof_pend;
  logic        r_align_err;

  logic        w_accept;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [23:0] w_pix;
  phase_t      w_phase_eff;
  phase_t      w_phase_nxt;
  logic [23:0] w_residual_nxt;
  logic        w_sof_pend_nxt;
  logic        w_err_set;
  axis_word_t  w_push_word;
  axis_word_t  w_head;

  // Ready comes only from the registered FIFO occupancy, never from tready.
  assign pix.in_stream_ready = ~w_full;
  assign w_accept            = pix.valid & pix.in_stream_ready;
  assign w_pix               = pack_pixel(pix.r, pix.g, pix.b);

  always_comb begin
    w_phase_eff      = pix.sof ? phase_t'(0) : r_phase;
    w_push           = 1'b0;
    w_push_word      = '0;
    w_push_word.keep = TKEEP_FULL;
    w_push_word.last = pix.eol;
    w_push_word.user = r_sof_pend | pix.sof;
    w_phase_nxt      = r_phase;
    w_residual_nxt   = r_residual;
    w_sof_pend_nxt   = r_sof_pend;
    w_err_set        = 1'b0;

    if (w_accept) begin
      case (w_phase_eff)
        2'd0: begin
          // A lone pixel closing a line is flushed as a 3-byte word.
          w_push           = pix.eol;
          w_push_word.data = {8'h00, w_pix};
          w_push_word.keep = TKEEP_3B;
          w_residual_nxt   = w_pix;
        end
        2'd1: begin
          w_push           = 1'b1;
          w_push_word.data = {w_pix[7:0], r_residual};
          w_residual_nxt   = {8'h00, w_pix[23:8]};
        end
        2'd2: begin
          w_push           = 1'b1;
          w_push_word.data = {w_pix[15:0], r_residual[15:0]};
          w_residual_nxt   = {16'h0000, w_pix[23:16]};
        end
        default: begin
          w_push           = 1'b1;
          w_push_word.data = {w_pix, r_residual[7:0]};
          w_residual_nxt   = '0;
        end
      endcase

      if (pix.eol) begin
        w_residual_nxt = '0;
        w_phase_nxt    = '0;
      end else if (w_phase_eff == phase_t'(PIX_PER_GROUP - 1)) begin
        w_phase_nxt    = '0;
      end else begin
        w_phase_nxt    = phase_t'(w_phase_eff + 2'd1);
      end

      w_sof_pend_nxt = w_push ? 1'b0 : (r_sof_pend | pix.sof);
      w_err_set      = (pix.sof && (r_phase != 2'd0)) ||
                       (pix.eol && (w_phase_eff != phase_t'(PIX_PER_GROUP - 1)));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase     <= '0;
      r_residual  <= '0;
      r_sof_pend  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_residual  <= w_residual_nxt;
      r_sof_pend  <= w_sof_pend_nxt;
      r_align_err <= r_align_err | w_err_set;
    end
  end

  assign align_err = r_align_err;

  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_push      (w_push),
    .i_push_word (w_push_word),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign w_pop                  = axis.out_stream_tvalid & axis.out_stream_tready;
  assign axis.out_stream_tvalid = ~w_empty;
  assign axis.out_stream_tdata  = w_head.data;
  assign axis.out_stream_tkeep  = w_head.keep;
  assign axis.out_stream_tlast  = w_head.last;
  assign axis.out_stream_tuser  = w_head.user;

endmodule

// File: tb/tb_rgb_word_packer.sv
// Randomised bench for rgb_word_packer against a byte-queue reference model.
module tb_rgb_word_packer;
  import video_pkg::*;

  localparam int FIFO_DEPTH = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic align_err;

  pix_stream_if pix ();
  axis_word_if  axis ();

  rgb_word_packer #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .pix       (pix),
    .axis      (axis),
    .align_err (align_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  logic rnd_ready = 1'b0;
  logic ready_val = 1'b0;
  logic gap_en    = 1'b0;

  // Reference state: stream bytes not yet forming a word, and words owed to the sink.
  logic [7:0] bytes_q [$];
  axis_word_t exp_q   [$];
  axis_word_t got     [$];
  logic       m_sof_pend = 1'b0;
  logic       m_err      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic sof, input logic eol);
    int n_emit;
    axis_word_t w;
    n_emit = 0;
    if (sof) begin
      if (bytes_q.size() != 0) m_err = 1'b1;
      bytes_q.delete();
      m_sof_pend = 1'b1;
    end
    bytes_q.push_back(r);
    bytes_q.push_back(g);
    bytes_q.push_back(b);
    while (bytes_q.size() >= 4) begin
      w.data = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
      w.keep = 4'hF;
      w.last = 1'b0;
      w.user = m_sof_pend;
      m_sof_pend = 1'b0;
      repeat (4) void'(bytes_q.pop_front());
      exp_q.push_back(w);
      n_emit++;
    end
    if (eol) begin
      if (bytes_q.size() != 0) begin
        m_err = 1'b1;
        if (n_emit == 0) begin
          w.data = {8'h00, bytes_q[2], bytes_q[1], bytes_q[0]};
          w.keep = 4'h7;
          w.last = 1'b0;
          w.user = m_sof_pend;
          m_sof_pend = 1'b0;
          exp_q.push_back(w);
        end
        bytes_q.delete();
      end
      w = exp_q.pop_back();
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  // Single compare process: everything observed at the falling edge.
  always @(negedge aclk) begin
    axis_word_t act;
    if (!aresetn) begin
      bytes_q.delete();
      exp_q.delete();
      m_sof_pend = 1'b0;
      m_err      = 1'b0;
    end else begin
      act.data = axis.out_stream_tdata;
      act.keep = axis.out_stream_tkeep;
      act.last = axis.out_stream_tlast;
      act.user = axis.out_stream_tuser;
      chk("tvalid", 64'(axis.out_stream_tvalid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(pix.in_stream_ready), 64'(exp_q.size() < FIFO_DEPTH));
      chk("align_err", 64'(align_err), 64'(m_err));
      if (axis.out_stream_tvalid && exp_q.size() != 0)
        chk("head_word", 64'(act), 64'(exp_q[0]));
      if (axis.out_stream_tvalid && axis.out_stream_tready) begin
        got.push_back(act);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (pix.valid && pix.in_stream_ready)
        model_accept(pix.r, pix.g, pix.b, pix.sof, pix.eol);
    end
  end

  always @(posedge aclk) begin
    #1;
    axis.out_stream_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic sof, input logic eol);
    int t;
    logic acc;
    if (gap_en) begin
      pix.valid = 1'b0;
      while ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
    pix.r = r; pix.g = g; pix.b = b;
    pix.sof = sof; pix.eol = eol;
    pix.valid = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 500) begin
      @(negedge aclk);
      acc = pix.in_stream_ready;
      @(posedge aclk);
      #1;
      t++;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: pixel not accepted in %0d cycles", t);
    end
    pix.valid = 1'b0;
    pix.sof   = 1'b0;
    pix.eol   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    repeat (2) @(negedge aclk);
    while ((axis.out_stream_tvalid || exp_q.size() != 0) && t < 4000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 4000) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: tvalid %0b pending %0d", axis.out_stream_tvalid, exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] d,
                         input logic [3:0] k, input logic l);
    if (idx < got.size()) begin
      chk({name, "_data"}, 64'(got[idx].data), 64'(d));
      chk({name, "_keep"}, 64'(got[idx].keep), 64'(k));
      chk({name, "_last"}, 64'(got[idx].last), 64'(l));
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: word %0d missing, only %0d received", name, idx, got.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx0;
    int nu;
    int nl;
    logic [7:0] br, bg, bb;

    aresetn = 1'b0;
    pix.valid = 1'b0; pix.sof = 1'b0; pix.eol = 1'b0;
    pix.r = '0; pix.g = '0; pix.b = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(axis.out_stream_tvalid), 64'(0));
    chk("rst_tdata", 64'(axis.out_stream_tdata), 64'(0));
    chk("rst_tkeep", 64'(axis.out_stream_tkeep), 64'(0));
    chk("rst_tlast", 64'(axis.out_stream_tlast), 64'(0));
    chk("rst_tuser", 64'(axis.out_stream_tuser), 64'(0));
    chk("rst_align_err", 64'(align_err), 64'(0));
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_in_ready", 64'(pix.in_stream_ready), 64'(1));
    @(posedge aclk);
    #1;

    // Basic packing
    ready_val = 1'b1;
    idx0 = got.size();
    send_pix(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send_pix(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    send_pix(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    send_pix(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0);
    drain();
    chk_got("basic_w0", idx0 + 0, 32'h04030201, 4'hF, 1'b0);
    chk_got("basic_w1", idx0 + 1, 32'h08070605, 4'hF, 1'b0);
    chk_got("basic_w2", idx0 + 2, 32'h0C0B0A09, 4'hF, 1'b0);

    // Back-pressure: sink stalled while 8 pixels are offered
    ready_val = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    idx0 = got.size();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_pix(8'(8'h10 + 3*i), 8'(8'h11 + 3*i), 8'(8'h12 + 3*i), 1'b0, 1'b0);
      end
      begin
        repeat (10) @(negedge aclk);
        chk("bp_in_ready_low", 64'(pix.in_stream_ready), 64'(0));
        chk("bp_hold_data_a", 64'(axis.out_stream_tdata), 64'(32'h13121110));
        repeat (3) @(negedge aclk);
        chk("bp_hold_data_b", 64'(axis.out_stream_tdata), 64'(32'h13121110));
        chk("bp_hold_valid", 64'(axis.out_stream_tvalid), 64'(1));
        ready_val = 1'b1;
      end
    join
    drain();
    chk("bp_word_count", 64'(got.size() - idx0), 64'(6));
    chk_got("bp_w0", idx0 + 0, 32'h13121110, 4'hF, 1'b0);
    chk_got("bp_w5", idx0 + 5, 32'h27262524, 4'hF, 1'b0);

    // One full frame line with random gaps and random sink stalls
    idx0 = got.size();
    gap_en = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < X_SIZE; i++) begin
      br = 8'($urandom_range(0, 255));
      bg = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      send_pix(br, bg, bb, i == 0, i == X_SIZE - 1);
    end
    rnd_ready = 1'b0;
    ready_val = 1'b1;
    gap_en = 1'b0;
    drain();
    chk("line_word_count", 64'(got.size() - idx0), 64'(480));
    nu = 0;
    nl = 0;
    for (int j = idx0; j < got.size(); j++) begin
      nu += int'(got[j].user);
      nl += int'(got[j].last);
    end
    chk("line_tuser_count", 64'(nu), 64'(1));
    chk("line_tlast_count", 64'(nl), 64'(1));
    if (got.size() >= idx0 + 480) begin
      chk("line_tuser_first", 64'(got[idx0].user), 64'(1));
      chk("line_tlast_final", 64'(got[idx0 + 479].last), 64'(1));
    end
    chk("line_align_err", 64'(align_err), 64'(0));

    // Misaligned eol at phase 1, then a fresh group
    idx0 = got.size();
    send_pix(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send_pix(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
    send_pix(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
    send_pix(8'h34, 8'h35, 8'h36, 1'b0, 1'b0);
    send_pix(8'h37, 8'h38, 8'h39, 1'b0, 1'b0);
    send_pix(8'h3A, 8'h3B, 8'h3C, 1'b0, 1'b0);
    drain();
    chk_got("eol_p1_w0", idx0 + 0, 32'h04030201, 4'hF, 1'b1);
    chk_got("eol_p1_next", idx0 + 1, 32'h34333231, 4'hF, 1'b0);
    chk("eol_p1_align_err", 64'(align_err), 64'(1));

    // Reset mid-group with one word queued
    ready_val = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    send_pix(8'h51, 8'h52, 8'h53, 1'b0, 1'b0);
    send_pix(8'h54, 8'h55, 8'h56, 1'b0, 1'b0);
    @(negedge aclk);
    chk("pre_rst_tvalid", 64'(axis.out_stream_tvalid), 64'(1));
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(axis.out_stream_tvalid), 64'(0));
    chk("midrst_tdata", 64'(axis.out_stream_tdata), 64'(0));
    chk("midrst_align_err", 64'(align_err), 64'(0));
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    chk("midrst_in_ready", 64'(pix.in_stream_ready), 64'(1));
    ready_val = 1'b1;
    @(posedge aclk);
    #1;
    idx0 = got.size();
    send_pix(8'h40, 8'h41, 8'h42, 1'b0, 1'b0);
    send_pix(8'h43, 8'h44, 8'h45, 1'b0, 1'b0);
    send_pix(8'h46, 8'h47, 8'h48, 1'b0, 1'b0);
    send_pix(8'h49, 8'h4A, 8'h4B, 1'b0, 1'b0);
    drain();
    chk("midrst_word_count", 64'(got.size() - idx0), 64'(3));
    chk_got("midrst_w0", idx0 + 0, 32'h43424140, 4'hF, 1'b0);
    chk_got("midrst_w2", idx0 + 2, 32'h4B4A4948, 4'hF, 1'b0);

    // Lone pixel closing a line at phase 0
    idx0 = got.size();
    send_pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b1);
    drain();
    chk_got("eol_p0", idx0, 32'h00332211, 4'h7, 1'b1);
    chk("eol_p0_align_err", 64'(align_err), 64'(1));

    // Random traffic with occasional markers anywhere in the group
    gap_en = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      br = 8'($urandom_range(0, 255));
      bg = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      send_pix(br, bg, bb, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end
    rnd_ready = 1'b0;
    ready_val = 1'b1;
    gap_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
